// File: rtl/lifted_port_scan_driver_if.sv
// Bus between host-side scan control, the scan driver and the partial module's lifted nets.
// Optional LIFTED_SCAN_PARITY_EN adds the parity_err status signal.
interface lifted_port_scan_driver_if #(
   parameter int unsigned NUM_IN  = 4,
   parameter int unsigned NUM_OUT = 3
);
   logic               scan_start;
   logic               scan_in;
   logic               scan_out;
   logic               busy;
   logic               done;
   logic [NUM_OUT-1:0] lifted_output;
   logic [NUM_IN-1:0]  lifted_input;
`ifdef LIFTED_SCAN_PARITY_EN
   logic               parity_err;
`endif

   // Host / partial-module side
   modport master (
      output scan_start, scan_in, lifted_output,
      input  scan_out, busy, done, lifted_input
`ifdef LIFTED_SCAN_PARITY_EN
      , input parity_err
`endif
   );

   // Scan driver side
   modport slave (
      input  scan_start, scan_in, lifted_output,
      output scan_out, busy, done, lifted_input
`ifdef LIFTED_SCAN_PARITY_EN
      , output parity_err
`endif
   );
endinterface

// File: rtl/lifted_port_scan_driver.sv
// Scan stage around a partially-extracted module: captures lifted outputs, shifts the chain
// serially, then updates the registered lifted-input drive.
// Optional feature macro: LIFTED_SCAN_PARITY_EN (parity check cycle before update, parity_err).
module lifted_port_scan_driver #(
   parameter int unsigned NUM_IN  = 4,
   parameter int unsigned NUM_OUT = 3
) (
   input logic CLK,
   input logic ASYNCRESETN,
   lifted_port_scan_driver_if.slave bus
);
   localparam int unsigned L  = NUM_IN + NUM_OUT;
   localparam int unsigned CW = $clog2(L + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_SHIFT,
`ifdef LIFTED_SCAN_PARITY_EN
      ST_PARITY,
`endif
      ST_UPDATE
   } state_t;

   state_t            state, state_d;
   logic [L-1:0]      sr, sr_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic [NUM_IN-1:0] li, li_d;
   logic              busy, busy_d;
   logic              done, done_d;
`ifdef LIFTED_SCAN_PARITY_EN
   logic              perr, perr_d;
`endif

   // Next-state and next-register values
   always_comb begin
      state_d = state;
      sr_d    = sr;
      cnt_d   = cnt;
      li_d    = li;
      done_d  = 1'b0;
`ifdef LIFTED_SCAN_PARITY_EN
      perr_d  = perr;
`endif
      case (state)
         ST_IDLE: begin
            if (bus.scan_start) begin
               state_d = ST_CAPTURE;
`ifdef LIFTED_SCAN_PARITY_EN
               perr_d  = 1'b0;
`endif
            end
         end
         ST_CAPTURE: begin
            sr_d    = {li, bus.lifted_output};
            cnt_d   = CW'(0);
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            sr_d  = {bus.scan_in, sr[L-1:1]};
            cnt_d = cnt + CW'(1);
            if (cnt == CW'(L - 1)) begin
`ifdef LIFTED_SCAN_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_UPDATE;
`endif
            end
         end
`ifdef LIFTED_SCAN_PARITY_EN
         ST_PARITY: begin
            // sr now holds exactly the L bits shifted in; a bad parity bit skips the update
            if (bus.scan_in != (^sr)) begin
               perr_d  = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_UPDATE;
            end
         end
`endif
         ST_UPDATE: begin
            li_d    = sr[L-1:NUM_OUT];
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state <= ST_IDLE;
         sr    <= '0;
         cnt   <= '0;
         li    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef LIFTED_SCAN_PARITY_EN
         perr  <= 1'b0;
`endif
      end else begin
         state <= state_d;
         sr    <= sr_d;
         cnt   <= cnt_d;
         li    <= li_d;
         busy  <= busy_d;
         done  <= done_d;
`ifdef LIFTED_SCAN_PARITY_EN
         perr  <= perr_d;
`endif
      end
   end

   assign bus.scan_out     = sr[0];
   assign bus.busy         = busy;
   assign bus.done         = done;
   assign bus.lifted_input = li;
`ifdef LIFTED_SCAN_PARITY_EN
   assign bus.parity_err   = perr;
`endif
endmodule

// File: tb/tb_lifted_port_scan_driver.sv
// Self-checking bench for lifted_port_scan_driver (NUM_IN=4, NUM_OUT=3, L=7).
// Also covers the parity path when LIFTED_SCAN_PARITY_EN is defined.
module tb_lifted_port_scan_driver;
   localparam int unsigned NUM_IN  = 4;
   localparam int unsigned NUM_OUT = 3;

   logic CLK;
   logic ASYNCRESETN;

   lifted_port_scan_driver_if #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) bus ();

   lifted_port_scan_driver #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .bus         (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic       so_q[$];
   logic [3:0] li_q[$];
   logic [3:0] li_model;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One capture/shift/update sequence; entered #1 after an edge with the DUT idle
   task automatic run_seq(input logic [2:0] lo, input logic [6:0] si, input logic keep,
                          input logic bad_par);
      logic [3:0] old_li;
      logic       ok;
      logic       exp_so;
      logic [3:0] exp_li;
      old_li = li_model;
      ok     = 1'b1;
`ifdef LIFTED_SCAN_PARITY_EN
      ok     = !bad_par;
`endif
      for (int i = 0; i < 3; i++) so_q.push_back(lo[i]);
      for (int i = 0; i < 4; i++) so_q.push_back(old_li[i]);
      li_model = ok ? si[6:3] : old_li;
      li_q.push_back(li_model);

      bus.lifted_output = lo;
      bus.scan_start    = 1'b1;
      tick();                                   // accept edge
      check("busy_on", 32'(bus.busy), 32'd1);
      if (!keep) bus.scan_start = 1'b0;
      tick();                                   // capture edge
      for (int k = 0; k < 7; k++) begin
         bus.scan_in = si[k];
         exp_so = so_q.pop_front();
         check($sformatf("scan_out[%0d]", k), 32'(bus.scan_out), 32'(exp_so));
         check("li_stable", 32'(bus.lifted_input), 32'(old_li));
         check("busy_hold", 32'(bus.busy), 32'd1);
         tick();
      end
`ifdef LIFTED_SCAN_PARITY_EN
      bus.scan_in = (^si) ^ bad_par;
      check("done_pre_par", 32'(bus.done), 32'd0);
      tick();                                   // parity edge
      if (ok) begin
         check("done_pre", 32'(bus.done), 32'd0);
         tick();                                // update edge
      end
`else
      check("done_pre", 32'(bus.done), 32'd0);
      tick();                                   // update edge
`endif
      bus.scan_in = 1'b0;
      exp_li = li_q.pop_front();
      check("done_pulse", 32'(bus.done), 32'd1);
      check("busy_off", 32'(bus.busy), 32'd0);
      check("lifted_input", 32'(bus.lifted_input), 32'(exp_li));
`ifdef LIFTED_SCAN_PARITY_EN
      check("parity_err", 32'(bus.parity_err), 32'(!ok));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      ASYNCRESETN       = 1'b0;
      bus.scan_start    = 1'b0;
      bus.scan_in       = 1'b0;
      bus.lifted_output = '0;
      li_model          = 4'b0000;
      tick();
      tick();
      ASYNCRESETN = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("rst_li", 32'(bus.lifted_input), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_scan_out", 32'(bus.scan_out), 32'd0);
`ifdef LIFTED_SCAN_PARITY_EN
      check("rst_parity_err", 32'(bus.parity_err), 32'd0);
`endif

      // Basic: scan_in bits 0..6 = 0,0,0,1,0,1,1
      run_seq(3'b101, 7'b1101000, 1'b0, 1'b0);
      tick();
      check("done_one_cycle", 32'(bus.done), 32'd0);

      // Old inputs come back out, all-zero update
      run_seq(3'b010, 7'b0000000, 1'b0, 1'b0);
      tick();
      check("done_one_cycle2", 32'(bus.done), 32'd0);

      // scan_start held through the whole sequence and into the done cycle
      run_seq(3'b011, 7'b1011010, 1'b1, 1'b0);
      run_seq(3'b110, 7'b0111001, 1'b0, 1'b0);
      tick();
      check("b2b_idle_busy", 32'(bus.busy), 32'd0);
      check("b2b_idle_done", 32'(bus.done), 32'd0);

      // Asynchronous reset after SHIFT cycle 3
      bus.lifted_output = 3'b111;
      bus.scan_start    = 1'b1;
      tick();
      bus.scan_start = 1'b0;
      tick();
      bus.scan_in = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("pre_rst_scan_out", 32'(bus.scan_out), 32'(li_model[0]));
      #2 ASYNCRESETN = 1'b0;
      #1;
      check("arst_li", 32'(bus.lifted_input), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_scan_out", 32'(bus.scan_out), 32'd0);
      #2 ASYNCRESETN = 1'b1;
      bus.scan_in = 1'b0;
      so_q.delete();
      li_q.delete();
      li_model = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("arst_no_done", 32'(bus.done), 32'd0);
      end
      check("arst_li_after", 32'(bus.lifted_input), 32'd0);

`ifdef LIFTED_SCAN_PARITY_EN
      // Good parity applies, bad parity leaves the drive alone and flags the error
      run_seq(3'b101, 7'b1101000, 1'b0, 1'b0);
      tick();
      run_seq(3'b010, 7'b0001111, 1'b0, 1'b1);
      tick();
      check("perr_hold", 32'(bus.parity_err), 32'd1);
      check("perr_li_kept", 32'(bus.lifted_input), 32'b1101);
      run_seq(3'b001, 7'b0010110, 1'b0, 1'b0);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
